prog_loader: RTL and testbench

Boot-time program loader and core-reset sequencer for riscv_cpu. Receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port. Holds the core in reset while loading, then releases it. Sits beside riscv_cpu at SoC top level and owns the core's reset input.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader_byte_packer.sv | 34 +++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot program loader: state encoding and byte-lane geometry.
package prog_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int LANES      = 4;
    localparam int WORD_W     = BYTE_W * LANES;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_loading(state_t s);
        return (s == ST_LEN) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic                byte_valid;
    logic [BYTE_W-1:0]   byte_data;
    logic                byte_ready;
    logic                imem_we;
    logic [31:0]         imem_addr;
    logic [WORD_W-1:0]   imem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 4-byte assembler; word_next/word_done are valid in the cycle the last byte is taken.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               take,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic [WORD_W-1:0]  word_next,
    output logic               word_done
);

    logic [LANE_IDX_W-1:0] byte_cnt;
    logic [WORD_W-1:0]     word;

    always_comb begin
        word_next = word;
        word_next[int'(byte_cnt) * BYTE_W +: BYTE_W] = byte_data;
    end

    assign word_done = take && (byte_cnt == LANE_IDX_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (take) begin
            byte_cnt <= byte_cnt + 1'b1;
            word     <= word_next;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot program loader: receives length header plus image bytes, writes imem, then releases the core.
//   state | meaning
//   IDLE  | core held in reset, waiting for start/skip
//   LEN   | collecting 4-byte little-endian word count
//   DATA  | collecting image words; one write cycle after each 4th byte
//   RUN   | core released
//   ERR   | bad header or byte timeout; core held in reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          skip,
    prog_loader_if.master link,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    state_t              state, state_next;
    logic                take;
    logic [WORD_W-1:0]   pk_word;
    logic                pk_done;
    logic [31:0]         word_count;
    logic [29:0]         word_idx;
    logic [CNT_W-1:0]    idle_cnt;
    logic                timeout, last_word, hdr_bad;

    logic                cpu_reset_nx, byte_ready_nx, we_nx, busy_nx, done_nx, error_nx;
    logic [31:0]         addr_nx;
    logic [WORD_W-1:0]   wdata_nx;

    assign take      = link.byte_valid && link.byte_ready;
    assign timeout   = is_loading(state) && !take && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign last_word = ({2'b00, word_idx} == (word_count - 32'd1));
    assign hdr_bad   = (pk_word == '0) || (pk_word > 32'(IMEM_DEPTH));

    prog_loader_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (!is_loading(state)),
        .take      (take),
        .byte_data (link.byte_data),
        .word_next (pk_word),
        .word_done (pk_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start)     state_next = ST_LEN;
                else if (skip) state_next = ST_RUN;
            end
            ST_LEN: begin
                if (take && pk_done) state_next = hdr_bad ? ST_ERR : ST_DATA;
                else if (timeout)    state_next = ST_ERR;
            end
            ST_DATA: begin
                // link.imem_we high marks the write cycle inside DATA
                if (link.imem_we && last_word) state_next = ST_RUN;
                else if (timeout)              state_next = ST_ERR;
            end
            ST_RUN:  if (start) state_next = ST_LEN;
            ST_ERR:  if (start) state_next = ST_LEN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_reset_nx  = (state_next != ST_RUN);
        busy_nx       = is_loading(state_next);
        done_nx       = (state_next == ST_RUN);
        error_nx      = (state_next == ST_ERR);
        we_nx         = (state == ST_DATA) && take && pk_done;
        byte_ready_nx = (state_next == ST_LEN) || ((state_next == ST_DATA) && !we_nx);
        addr_nx       = we_nx ? {word_idx, 2'b00} : link.imem_addr;
        wdata_nx      = we_nx ? pk_word : link.imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            link.byte_ready <= 1'b0;
            link.imem_we    <= 1'b0;
            link.imem_addr  <= '0;
            link.imem_wdata <= '0;
        end else begin
            cpu_reset       <= cpu_reset_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            error           <= error_nx;
            link.byte_ready <= byte_ready_nx;
            link.imem_we    <= we_nx;
            link.imem_addr  <= addr_nx;
            link.imem_wdata <= wdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
            word_idx   <= '0;
            idle_cnt   <= '0;
        end else begin
            if ((state == ST_LEN) && take && pk_done) word_count <= pk_word;
            if (state == ST_LEN)                      word_idx <= '0;
            else if (link.imem_we && !last_word)      word_idx <= word_idx + 30'd1;
            idle_cnt <= (take || !is_loading(state_next)) ? '0 : idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, skip, header errors, byte timeout, reload and reset mid-load.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic skip = 1'b0;
    logic cpu_reset, busy, done, error;

    int checks = 0;
    int failures = 0;
    int wcount = 0;
    logic [31:0] waddr [8];
    logic [31:0] wdata [8];
    int wbase;

    prog_loader_if bus ();

    prog_loader #(
        .IMEM_DEPTH  (256),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .skip      (skip),
        .link      (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wcount < 8) begin
                waddr[wcount] = bus.imem_addr;
                wdata[wcount] = bus.imem_wdata;
            end
            wcount = wcount + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        skip  = 1'b0;
        bus.byte_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},      32'(dut.state), 32'(ST_IDLE));
        check({tag, "_cpu_reset"},  32'(cpu_reset), 32'd1);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_imem_we"},    32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"},  bus.imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_done"},       32'(done), 32'd0);
        check({tag, "_error"},      32'(error), 32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // 1: two-word load
        do_reset();
        check_reset_outputs("rst1");
        pulse_start();
        check("t1_busy_len", 32'(busy), 32'd1);
        check("t1_state_len", 32'(dut.state), 32'(ST_LEN));
        send_word(32'h0000_0002);
        check("t1_state_data", 32'(dut.state), 32'(ST_DATA));
        send_word(32'h0010_0513);
        send_word(32'h0020_0593);
        check("t1_we2", 32'(bus.imem_we), 32'd1);
        check("t1_addr2", bus.imem_addr, 32'h0000_0004);
        check("t1_data2", bus.imem_wdata, 32'h0020_0593);
        check("t1_ready_wr", 32'(bus.byte_ready), 32'd0);
        check("t1_cpu_reset_wr", 32'(cpu_reset), 32'd1);
        tick();
        check("t1_cpu_reset_run", 32'(cpu_reset), 32'd0);
        check("t1_done_run", 32'(done), 32'd1);
        check("t1_busy_run", 32'(busy), 32'd0);
        check("t1_we_after", 32'(bus.imem_we), 32'd0);
        check("t1_wcount", 32'(wcount), 32'd2);
        check("t1_log_addr0", waddr[0], 32'h0000_0000);
        check("t1_log_data0", wdata[0], 32'h0010_0513);
        check("t1_log_addr1", waddr[1], 32'h0000_0004);
        check("t1_log_data1", wdata[1], 32'h0020_0593);

        // 2: skip straight to run
        do_reset();
        check("t2_cpu_reset_idle", 32'(cpu_reset), 32'd1);
        wbase = wcount;
        skip = 1'b1;
        tick();
        skip = 1'b0;
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        tick();
        check("t2_busy_hold", 32'(busy), 32'd0);
        check("t2_wcount", 32'(wcount), 32'(wbase));

        // 3: zero-length header
        do_reset();
        wbase = wcount;
        pulse_start();
        send_word(32'h0000_0000);
        check("t3_state_err", 32'(dut.state), 32'(ST_ERR));
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_ready", 32'(bus.byte_ready), 32'd0);
        check("t3_wcount", 32'(wcount), 32'(wbase));
        pulse_start();
        check("t3_error_clear", 32'(error), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);

        // 4: oversize header (257 words)
        send_word(32'h0000_0101);
        check("t4_error", 32'(error), 32'd1);
        check("t4_state_err", 32'(dut.state), 32'(ST_ERR));
        check("t4_wcount", 32'(wcount), 32'(wbase));

        // 5: byte gaps against a 16-cycle timeout
        pulse_start();
        send_word(32'h0000_0001);
        send_byte(8'hAA);
        bus.byte_valid = 1'b0;
        repeat (15) tick();
        check("t5_gap15_ready", 32'(bus.byte_ready), 32'd1);
        check("t5_gap15_error", 32'(error), 32'd0);
        send_byte(8'hBB);
        repeat (15) tick();
        check("t5_gap15b_busy", 32'(busy), 32'd1);
        tick();
        check("t5_gap16_error", 32'(error), 32'd1);
        check("t5_gap16_state", 32'(dut.state), 32'(ST_ERR));
        check("t5_gap16_ready", 32'(bus.byte_ready), 32'd0);

        // 6: reload from RUN, reset mid-load, start+skip together
        do_reset();
        skip = 1'b1;
        tick();
        skip = 1'b0;
        check("t6_run", 32'(done), 32'd1);
        pulse_start();
        check("t6_reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_reload_state", 32'(dut.state), 32'(ST_LEN));
        check("t6_reload_done", 32'(done), 32'd0);
        send_word(32'h0000_0001);
        send_byte(8'h11);
        send_byte(8'h22);
        check("t6_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("t6_rst");
        start = 1'b1;
        skip  = 1'b1;
        tick();
        start = 1'b0;
        skip  = 1'b0;
        check("t6_both_state", 32'(dut.state), 32'(ST_LEN));
        check("t6_both_busy", 32'(busy), 32'd1);
        check("t6_both_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
